// File: rtl/alif_pkg.sv
// Shared types and default widths for the ALIF neuron scheduler.
package alif_pkg;

    localparam int V_W  = 8;
    localparam int TH_W = 8;
    localparam int I_W  = 8;

    localparam logic [7:0] TH_INIT = 8'd64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMMIT
    } sched_state_t;

endpackage

// File: rtl/alif_spike_fifo.sv
// Small synchronous FIFO for spike indices. Pop uses a valid/ready handshake.
// A push into a full FIFO is dropped unless a pop happens in the same cycle,
// and the drop is reported for one cycle on the drop output.
module alif_spike_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic              drop
);
    import alif_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = !empty;
    assign do_pop  = valid && pop_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    // Head is forced to zero while empty so the output is clean after reset.
    assign head_data = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; emptiness is
        // defined by the pointers/count, and unreset storage maps to plain flops/RAM.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alif_scheduler.sv
// Time-multiplexes one ALIF update datapath across NUM_NEURONS virtual neurons.
// Each tick sweeps neurons 0..N-1: issue operands, wait for the datapath,
// commit the results into the local banks and queue spike events.
module alif_scheduler #(
    parameter int              NUM_NEURONS = 4,
    parameter int              V_W         = alif_pkg::V_W,
    parameter int              TH_W        = alif_pkg::TH_W,
    parameter int              I_W         = alif_pkg::I_W,
    parameter logic [TH_W-1:0] TH_INIT     = TH_W'(alif_pkg::TH_INIT),
    parameter int              FIFO_DEPTH  = 4,
    localparam int             IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [I_W-1:0]   cur_wdata,
    output logic             dp_start,
    output logic [IDX_W-1:0] dp_idx,
    output logic [V_W-1:0]   dp_v_in,
    output logic [TH_W-1:0]  dp_th_in,
    output logic [I_W-1:0]   dp_i_in,
    input  logic             dp_done,
    input  logic [V_W-1:0]   dp_v_out,
    input  logic [TH_W-1:0]  dp_th_out,
    input  logic             dp_spike,
    output logic             spk_valid,
    output logic [IDX_W-1:0] spk_idx,
    input  logic             spk_ready,
    output logic             busy,
    output logic             sweep_done,
    output logic             spk_ovf,
    output logic             tick_miss,
    input  logic             clr_flags
);
    import alif_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] load_idx;

    logic [V_W-1:0]   v_bank   [NUM_NEURONS];
    logic [TH_W-1:0]  th_bank  [NUM_NEURONS];
    logic [I_W-1:0]   cur_bank [NUM_NEURONS];

    // Datapath results captured on dp_done, written back in COMMIT.
    logic [V_W-1:0]   v_res;
    logic [TH_W-1:0]  th_res;
    logic             spike_res;

    logic             fifo_push;
    logic             fifo_drop;

    assign next_idx  = idx + IDX_W'(1);
    // Operands are loaded either for neuron 0 (leaving IDLE) or for the next neuron (leaving COMMIT).
    assign load_idx  = (state == S_IDLE) ? '0 : next_idx;
    assign busy      = (state != S_IDLE);
    assign dp_idx    = idx;
    assign fifo_push = (state == S_COMMIT) && spike_res;

    // Sweep FSM: issues each neuron, waits for the datapath and commits the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            dp_start   <= 1'b0;
            dp_v_in    <= '0;
            dp_th_in   <= '0;
            dp_i_in    <= '0;
            sweep_done <= 1'b0;
            v_res      <= '0;
            th_res     <= '0;
            spike_res  <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_bank[n]  <= '0;
                th_bank[n] <= TH_INIT;
            end
        end else begin
            dp_start   <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx      <= '0;
                        dp_start <= 1'b1;
                        dp_v_in  <= v_bank[load_idx];
                        dp_th_in <= th_bank[load_idx];
                        dp_i_in  <= cur_bank[load_idx];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (dp_done) begin
                        v_res     <= dp_v_out;
                        th_res    <= dp_th_out;
                        spike_res <= dp_spike;
                        state     <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    v_bank[idx]  <= v_res;
                    th_bank[idx] <= th_res;
                    if (idx == LAST_IDX) begin
                        sweep_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        idx      <= next_idx;
                        dp_start <= 1'b1;
                        dp_v_in  <= v_bank[load_idx];
                        dp_th_in <= th_bank[load_idx];
                        dp_i_in  <= cur_bank[load_idx];
                        state    <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Input current bank; a write lands on the next cycle and persists across sweeps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) cur_bank[n] <= '0;
        end else if (cur_we) begin
            cur_bank[cur_addr] <= cur_wdata;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_ovf   <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            if (fifo_drop)      spk_ovf <= 1'b1;
            else if (clr_flags) spk_ovf <= 1'b0;

            if (tick && busy)   tick_miss <= 1'b1;
            else if (clr_flags) tick_miss <= 1'b0;
        end
    end

    alif_spike_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (IDX_W)
    ) u_spike_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (idx),
        .pop_ready (spk_ready),
        .valid     (spk_valid),
        .head_data (spk_idx),
        .drop      (fifo_drop)
    );

endmodule

// File: tb/tb_alif_scheduler.sv
// Directed bench for alif_scheduler with a sweep-level reference model.
module tb_alif_scheduler;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       cur_we = 1'b0;
    logic [1:0] cur_addr = '0;
    logic [7:0] cur_wdata = '0;
    logic       dp_start;
    logic [1:0] dp_idx;
    logic [7:0] dp_v_in;
    logic [7:0] dp_th_in;
    logic [7:0] dp_i_in;
    logic       dp_done = 1'b0;
    logic [7:0] dp_v_out = '0;
    logic [7:0] dp_th_out = '0;
    logic       dp_spike = 1'b0;
    logic       spk_valid;
    logic [1:0] spk_idx;
    logic       spk_ready = 1'b0;
    logic       busy;
    logic       sweep_done;
    logic       spk_ovf;
    logic       tick_miss;
    logic       clr_flags = 1'b0;

    alif_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cur_we     (cur_we),
        .cur_addr   (cur_addr),
        .cur_wdata  (cur_wdata),
        .dp_start   (dp_start),
        .dp_idx     (dp_idx),
        .dp_v_in    (dp_v_in),
        .dp_th_in   (dp_th_in),
        .dp_i_in    (dp_i_in),
        .dp_done    (dp_done),
        .dp_v_out   (dp_v_out),
        .dp_th_out  (dp_th_out),
        .dp_spike   (dp_spike),
        .spk_valid  (spk_valid),
        .spk_idx    (spk_idx),
        .spk_ready  (spk_ready),
        .busy       (busy),
        .sweep_done (sweep_done),
        .spk_ovf    (spk_ovf),
        .tick_miss  (tick_miss),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-neuron state as the specification defines it.
    logic [7:0] v_m  [N];
    logic [7:0] th_m [N];
    logic [7:0] i_m  [N];
    int         exp_q[$];
    int         exp_drops = 0;
    int         exp_pos = 0;

    // Datapath environment settings.
    int         cur_L = 1;
    logic [3:0] fire_mask = '0;
    logic [7:0] th_step = '0;
    bit         pop_on_commit = 1'b0;
    int         rst_gen = 0;
    bit         late_done_sent = 1'b0;

    // Observation state shared with the main thread.
    int         tick_cyc = 0;
    int         last_start = 0;
    int         busy_cnt = 0;
    int         n_starts = 0;
    bit         done_seen = 1'b0;
    int         last_done_edges = 0;
    int         last_busy = 0;
    int         start_cyc [N];
    logic [7:0] last_v_in [N];
    logic [7:0] last_th_in [N];
    logic [7:0] held_v, held_th, held_i;
    logic [1:0] held_idx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare process: issued operands against the model, operand stability and sweep timing.
    always @(negedge clk) begin
        int idx_e;
        if (!rst) begin
            if (tick && !busy) begin
                tick_cyc = cyc;
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (dp_start) begin
                n_starts++;
                idx_e = exp_pos % N;
                check("dp_idx", dp_idx, idx_e);
                check("dp_v_in", dp_v_in, v_m[idx_e]);
                check("dp_th_in", dp_th_in, th_m[idx_e]);
                check("dp_i_in", dp_i_in, i_m[idx_e]);
                if (idx_e == 0) check("issue_after_tick", cyc - tick_cyc, 1);
                else            check("issue_spacing", cyc - last_start, cur_L + 2);
                start_cyc[idx_e]  = cyc;
                last_v_in[idx_e]  = dp_v_in;
                last_th_in[idx_e] = dp_th_in;
                held_v = dp_v_in; held_th = dp_th_in; held_i = dp_i_in; held_idx = dp_idx;
                last_start = cyc;
                exp_pos++;
                v_m[idx_e]  = v_m[idx_e] + i_m[idx_e];
                th_m[idx_e] = th_m[idx_e] + th_step;
            end else if (busy) begin
                check("hold_v", dp_v_in, held_v);
                check("hold_th", dp_th_in, held_th);
                check("hold_i", dp_i_in, held_i);
                check("hold_idx", dp_idx, held_idx);
            end
            if (sweep_done) begin
                done_seen       = 1'b1;
                last_done_edges = cyc - tick_cyc - 1;
                last_busy       = busy_cnt;
                check("done_edges", last_done_edges, N * (cur_L + 2));
                check("busy_cycles", busy_cnt, N * (cur_L + 2));
                check("idle_at_done", busy, 0);
            end
        end
    end

    // Datapath responder: v_out = v+i, th_out = th+th_step, spike from fire_mask, latency cur_L.
    initial begin : responder
        logic [7:0] rv, rth, ri;
        int         ridx;
        int         rgen;
        bit         fire;
        forever begin
            @(negedge clk);
            if (dp_start && !rst) begin
                rv = dp_v_in; rth = dp_th_in; ri = dp_i_in; ridx = int'(dp_idx); rgen = rst_gen;
                fire = fire_mask[ridx];
                repeat (cur_L) @(posedge clk);
                #1;
                if (rgen != rst_gen) late_done_sent = 1'b1;
                dp_v_out  = rv + ri;
                dp_th_out = rth + th_step;
                dp_spike  = fire;
                dp_done   = 1'b1;
                @(posedge clk);
                #1;
                dp_done  = 1'b0;
                dp_spike = 1'b0;
                if (rgen == rst_gen && fire) begin
                    if (pop_on_commit) begin
                        check("head_before_pop_valid", spk_valid, 1);
                        check("head_before_pop", spk_idx, exp_q[0]);
                        spk_ready = 1'b1;
                        void'(exp_q.pop_front());
                        exp_q.push_back(ridx);
                        @(posedge clk);
                        #1;
                        spk_ready = 1'b0;
                    end else if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(ridx);
                    end else begin
                        exp_drops++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rst_gen++;
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < N; n++) begin
            v_m[n] = '0; th_m[n] = 8'd64; i_m[n] = '0;
        end
        exp_q.delete();
        exp_drops = 0;
        exp_pos = 0;
    endtask

    task automatic write_cur(input int n, input logic [7:0] val);
        cur_we = 1'b1; cur_addr = n[1:0]; cur_wdata = val;
        step();
        cur_we = 1'b0;
        i_m[n] = val;
    endtask

    task automatic run_sweep(input int lat);
        cur_L = lat;
        done_seen = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 400 && !done_seen; k++) step();
        check("sweep_done_seen", done_seen, 1);
    endtask

    task automatic wait_issue(input int want, output bit found);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (dp_start && dp_idx == want[1:0]) found = 1'b1;
        end
    endtask

    task automatic drain(input int n_exp);
        check("model_fifo_size", exp_q.size(), n_exp);
        for (int k = 0; k < n_exp; k++) begin
            check("drain_valid", spk_valid, 1);
            check("drain_idx", spk_idx, exp_q[0]);
            spk_ready = 1'b1;
            void'(exp_q.pop_front());
            step();
        end
        spk_ready = 1'b0;
        check("drain_empty", spk_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin : main
        bit found;
        int n0;
        int exp_full [4];

        // Reset state: all outputs zero.
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_spk_idx", spk_idx, 0);
        check("rst_spk_ovf", spk_ovf, 0);
        check("rst_tick_miss", tick_miss, 0);
        check("rst_dp_idx", dp_idx, 0);
        check("rst_dp_v_in", dp_v_in, 0);
        check("rst_dp_th_in", dp_th_in, 0);
        check("rst_dp_i_in", dp_i_in, 0);

        // First sweep at L=1: 3 cycles per neuron, 12 busy cycles.
        run_sweep(1);
        check("t1_busy_12", last_busy, 12);
        check("t1_done_12_edges", last_done_edges, 12);
        for (int n = 1; n < N; n++) check("t1_spacing_3", start_cyc[n] - start_cyc[n-1], 3);
        for (int n = 0; n < N; n++) check("t1_th_64", last_th_in[n], 64);

        // Write-back: currents {5,10,15,20}; second sweep sees them in v.
        write_cur(0, 8'd5);
        write_cur(1, 8'd10);
        write_cur(2, 8'd15);
        write_cur(3, 8'd20);
        run_sweep(1);
        for (int n = 0; n < N; n++) check("t2_first_v_zero", last_v_in[n], 0);
        run_sweep(2);
        check("t2_v0", last_v_in[0], 5);
        check("t2_v1", last_v_in[1], 10);
        check("t2_v2", last_v_in[2], 15);
        check("t2_v3", last_v_in[3], 20);
        for (int n = 0; n < N; n++) check("t2_th_64", last_th_in[n], 64);

        // Every neuron fires for two sweeps with no consumer: second sweep drops four.
        fire_mask = 4'b1111;
        th_step = 8'd1;
        run_sweep(1);
        check("t3_no_ovf_yet", spk_ovf, 0);
        check("t3_valid", spk_valid, 1);
        run_sweep(1);
        check("t3_ovf", spk_ovf, 1);
        check("t3_drops", exp_drops, 4);
        check("t3_th_written", last_th_in[0], 65);
        for (int n = 0; n < N; n++) check("t3_model_order", exp_q[n], n);
        drain(4);

        // Full FIFO with a pop during a spiking COMMIT: no drop, new index at the tail.
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t4_ovf_cleared", spk_ovf, 0);
        run_sweep(1);
        fire_mask = 4'b0001;
        pop_on_commit = 1'b1;
        run_sweep(1);
        pop_on_commit = 1'b0;
        check("t4_no_ovf", spk_ovf, 0);
        exp_full = '{1, 2, 3, 0};
        for (int n = 0; n < DEPTH; n++) check("t4_model_order", exp_q[n], exp_full[n]);
        drain(4);

        // Tick during WAIT of neuron 2 at L=5, with a simultaneous clear.
        fire_mask = 4'b0000;
        fork
            run_sweep(5);
            begin
                wait_issue(2, found);
                check("t5_issue2_found", found, 1);
                step();
                tick = 1'b1;
                clr_flags = 1'b1;
                step();
                tick = 1'b0;
                clr_flags = 1'b0;
                check("t5_miss_set_over_clr", tick_miss, 1);
            end
        join
        n0 = n_starts;
        repeat (30) step();
        check("t5_no_second_sweep", n_starts - n0, 0);
        check("t5_idle", busy, 0);
        check("t5_miss_sticky", tick_miss, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t5_miss_cleared", tick_miss, 0);

        // Reset in WAIT of neuron 1, then a late dp_done arrives while IDLE.
        fire_mask = 4'b1111;
        cur_L = 5;
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_issue(1, found);
        check("t6_issue1_found", found, 1);
        step();
        step();
        do_reset();
        n0 = n_starts;
        repeat (12) step();
        check("t6_late_done_driven", late_done_sent, 1);
        check("t6_busy", busy, 0);
        check("t6_fifo_empty", spk_valid, 0);
        check("t6_no_issue", n_starts - n0, 0);
        check("t6_no_flags", spk_ovf, 0);
        fire_mask = 4'b0000;
        th_step = 8'd0;
        run_sweep(1);
        for (int n = 0; n < N; n++) check("t6_v_cleared", last_v_in[n], 0);
        for (int n = 0; n < N; n++) check("t6_th_reinit", last_th_in[n], 64);
        check("t6_fifo_still_empty", spk_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
